mux3_arbiter: RTL and testbench



---
 rtl/mux3_arbiter.sv | 113 +++++++++++
 tb/tb_mux3_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mux3_arbiter.sv
// mux3_arbiter: round-robin arbiter driving the select of a shared 3:1 datapath mux.
// Latency: a request seen in IDLE is granted on the same edge; one idle cycle between owners.
// Backpressure: no preemption; an owner keeps the mux until it drops req or MAX_HOLD expires.
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   reset    - synchronous, active-high reset
//   req[2:0] - per-requester request, held high while using the mux
//   gnt[2:0] - registered one-hot grant, 000 when idle
//   sel[1:0] - registered mux select, index of current or most recent owner (never 2'b11)
//   busy     - high while any grant is active
//   timeout  - one-cycle pulse in the cycle after a grant is forcibly revoked
module mux3_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  state_t     state, state_nx;
  logic [1:0] last, last_nx;
  logic [1:0] owner, owner_nx;
  logic [1:0] sel_nx;
  logic [2:0] gnt_nx;
  logic [7:0] hold_cnt, hold_nx;
  logic       timeout_nx;

  // Round-robin search order: last+1, last+2, then last itself (mod 3).
  logic [1:0] cand1, cand2, pick;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  always_comb begin
    cand1 = inc3(last);
    cand2 = inc3(cand1);
    pick  = last;
    if (req[cand1])      pick = cand1;
    else if (req[cand2]) pick = cand2;
  end

  always_comb begin
    state_nx   = state;
    gnt_nx     = gnt;
    sel_nx     = sel;
    last_nx    = last;
    owner_nx   = owner;
    hold_nx    = hold_cnt;
    timeout_nx = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          owner_nx = pick;
          sel_nx   = pick;
          last_nx  = pick;
          gnt_nx   = 3'b001 << pick;
          hold_nx  = 8'd1;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        // Owner dropping req wins over the hold limit: that is a normal release.
        if (!req[owner]) begin
          gnt_nx   = 3'b000;
          state_nx = IDLE;
        end else if (hold_cnt == HOLD_LIMIT) begin
          gnt_nx     = 3'b000;
          timeout_nx = 1'b1;
          state_nx   = IDLE;
        end else begin
          hold_nx = hold_cnt + 8'd1;
        end
      end
      default: begin
        gnt_nx   = 3'b000;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= 3'b000;
      sel      <= 2'b00;
      last     <= 2'd2;
      owner    <= 2'd0;
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      sel      <= sel_nx;
      last     <= last_nx;
      owner    <= owner_nx;
      hold_cnt <= hold_nx;
      timeout  <= timeout_nx;
    end
  end

  assign busy = |gnt;

endmodule

// File: tb/tb_mux3_arbiter.sv
// tb_mux3_arbiter: directed vector bench for mux3_arbiter (MAX_HOLD=8 and MAX_HOLD=1 instances).
// Latency: inputs driven 1 time unit after a rising edge, outputs compared 1 unit after the next.
// Backpressure: none; stimulus is a fixed cycle-by-cycle schedule.
module tb_mux3_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req, req1;
  logic [2:0] gnt, gnt1;
  logic [1:0] sel, sel1;
  logic       busy, busy1, timeout, timeout1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux3_arbiter #(.MAX_HOLD(8)) u_dut (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
  );

  mux3_arbiter #(.MAX_HOLD(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1),
    .gnt(gnt1), .sel(sel1), .busy(busy1), .timeout(timeout1)
  );

  typedef struct {
    logic       rst;
    logic [2:0] rq;
    logic [2:0] eg;
    logic [1:0] es;
    logic       eb;
    logic       et;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic [2:0] rq, input logic [2:0] eg,
                     input logic [1:0] es, input logic eb, input logic et);
    vec_t v;
    v.rst = rst; v.rq = rq; v.eg = eg; v.es = es; v.eb = eb; v.et = et;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] g, input logic [1:0] s,
                     input logic b, input logic t, input logic [2:0] eg,
                     input logic [1:0] es, input logic eb, input logic et);
    checks++;
    if (g !== eg || s !== es || b !== eb || t !== et) begin
      failures++;
      $display("FAIL %s: got gnt=%b sel=%b busy=%b timeout=%b, want gnt=%b sel=%b busy=%b timeout=%b",
               name, g, s, b, t, eg, es, eb, et);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 3'b000;
    req1  = 3'b000;

    // reset state
    add(1, 3'b000, 3'b000, 2'b00, 0, 0);
    // single requester 1 for 3 cycles, then release; sel holds 01
    add(0, 3'b010, 3'b010, 2'b01, 1, 0);
    add(0, 3'b010, 3'b010, 2'b01, 1, 0);
    add(0, 3'b010, 3'b010, 2'b01, 1, 0);
    add(0, 3'b000, 3'b000, 2'b01, 0, 0);
    add(0, 3'b000, 3'b000, 2'b01, 0, 0);
    // owner 0, others request; no preemption, then rotation 1 then 2
    add(0, 3'b001, 3'b001, 2'b00, 1, 0);
    add(0, 3'b111, 3'b001, 2'b00, 1, 0);
    add(0, 3'b110, 3'b000, 2'b00, 0, 0);
    add(0, 3'b110, 3'b010, 2'b01, 1, 0);
    add(0, 3'b101, 3'b000, 2'b01, 0, 0);
    add(0, 3'b101, 3'b100, 2'b10, 1, 0);
    add(0, 3'b000, 3'b000, 2'b10, 0, 0);
    // owner 2 up to hold_cnt=4, then reset mid-grant, then req=101 goes to 0
    for (int i = 0; i < 4; i++) add(0, 3'b100, 3'b100, 2'b10, 1, 0);
    add(1, 3'b101, 3'b000, 2'b00, 0, 0);
    add(0, 3'b101, 3'b001, 2'b00, 1, 0);
    add(0, 3'b000, 3'b000, 2'b00, 0, 0);
    // owner 0 holds to hold_cnt=8 and drops req on that edge: normal release
    for (int i = 0; i < 8; i++) add(0, 3'b001, 3'b001, 2'b00, 1, 0);
    add(0, 3'b000, 3'b000, 2'b00, 0, 0);
    add(0, 3'b000, 3'b000, 2'b00, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst;
      req   = vq[i].rq;
      step();
      chk($sformatf("vec%0d", i), gnt, sel, busy, timeout,
          vq[i].eg, vq[i].es, vq[i].eb, vq[i].et);
    end

    // all three requesting: 8-cycle grants rotating 0,1,2,0,1,2 with a timeout/idle cycle each
    reset = 1'b1;
    req   = 3'b111;
    step();
    chk("rr_reset", gnt, sel, busy, timeout, 3'b000, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    for (int g = 0; g < 6; g++) begin
      logic [1:0] o;
      o = 2'(g % 3);
      for (int c = 0; c < 8; c++) begin
        step();
        chk($sformatf("rr_g%0d_c%0d", g, c), gnt, sel, busy, timeout,
            3'b001 << o, o, 1'b1, 1'b0);
      end
      step();
      chk($sformatf("rr_g%0d_timeout", g), gnt, sel, busy, timeout,
          3'b000, o, 1'b0, 1'b1);
    end
    req = 3'b000;
    step();
    chk("rr_idle", gnt, sel, busy, timeout, 3'b000, 2'b10, 1'b0, 1'b0);

    // MAX_HOLD=1 with req=001 held: alternating one-cycle grant and timeout
    reset = 1'b1;
    step();
    chk("mh1_reset", gnt1, sel1, busy1, timeout1, 3'b000, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    req1  = 3'b001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("mh1_grant%0d", k), gnt1, sel1, busy1, timeout1, 3'b001, 2'b00, 1'b1, 1'b0);
      step();
      chk($sformatf("mh1_timeout%0d", k), gnt1, sel1, busy1, timeout1, 3'b000, 2'b00, 1'b0, 1'b1);
    end
    // dropping req on the single granted cycle is a normal release
    step();
    chk("mh1_regrant", gnt1, sel1, busy1, timeout1, 3'b001, 2'b00, 1'b1, 1'b0);
    req1 = 3'b000;
    step();
    chk("mh1_release", gnt1, sel1, busy1, timeout1, 3'b000, 2'b00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
